// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DBG = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 7;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way winner select: M1 lock first, then a lone requester,
// then round-robin against the last-granted master.
module arb_rr2
   import bus_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       lock,
   input  logic       last,
   output logic       win,
   output logic       valid
);

   always_comb begin
      valid = |req;
      win   = M_CPU;
      if (lock && req[1]) begin
         win = M_DBG;
      end else if (req == 2'b10) begin
         win = M_DBG;
      end else if (req == 2'b01) begin
         win = M_CPU;
      end else if (req == 2'b11) begin
         win = ~last;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter and sequencer for the miniLA data bus: one transaction at a
// time, registered bus drive, read latency counted for synchronous memory.
module data_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int AW     = 32
)
(
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_ack,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_ack,
   output logic [31:0]   m1_rdata,
   input  logic          m1_lock,
   output logic [AW-1:0] Bus_addr,
   output logic          Bus_we,
   output logic [31:0]   Bus_wdata,
   input  logic [31:0]   Bus_rdata
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("data_bus_arbiter: RD_LAT out of range 1..7");
   end

   localparam logic [2:0] LAT_END = 3'(RD_LAT);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       gnt_idx;
   logic       last_q;
   logic       bus_we_q;
   logic [2:0] lat_cnt;
   logic       win;
   logic       valid;
   logic       lat_done;

   arb_rr2 u_arb (
      .req   ({m1_req, m0_req}),
      .lock  (m1_lock),
      .last  (last_q),
      .win   (win),
      .valid (valid)
   );

   assign lat_done = (state == WAIT) && (lat_cnt == LAT_END);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = bus_we_q ? DONE : WAIT;
         WAIT:    if (lat_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The winner's request is copied once on IDLE->ISSUE; later changes on its
   // inputs (including dropping req) cannot disturb the transaction in flight.
   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst) begin
         state     <= IDLE;
         gnt_idx   <= M_CPU;
         last_q    <= M_DBG;
         bus_we_q  <= 1'b0;
         lat_cnt   <= 3'd0;
         Bus_addr  <= '0;
         Bus_wdata <= '0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && valid) begin
            gnt_idx   <= win;
            last_q    <= win;
            bus_we_q  <= (win == M_DBG) ? m1_we    : m0_we;
            Bus_addr  <= (win == M_DBG) ? m1_addr  : m0_addr;
            Bus_wdata <= (win == M_DBG) ? m1_wdata : m0_wdata;
         end
         if (state == ISSUE) begin
            lat_cnt <= 3'd1;
         end else if (state == WAIT && !lat_done) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         if (lat_done) begin
            if (gnt_idx == M_DBG) m1_rdata <= Bus_rdata;
            else                  m0_rdata <= Bus_rdata;
         end
      end
   end

   assign Bus_we = (state == ISSUE) && bus_we_q;
   assign m0_gnt = (state != IDLE) && (gnt_idx == M_CPU);
   assign m1_gnt = (state != IDLE) && (gnt_idx == M_DBG);
   assign m0_ack = (state == DONE) && (gnt_idx == M_CPU);
   assign m1_ack = (state == DONE) && (gnt_idx == M_DBG);

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter and sequencer for the single data bus (`Bus_addr` / `Bus_we` / `Bus_wdata` / `Bus_rdata`) behind the miniLA core. Master 0 is the CPU data port. Master 1 is the debug/program-loader port. The block grants one master per transaction with round-robin fairness and a master-1 lock, drives the bus from registered copies of the request, and sequences read latency for synchronous memory. Each master receives a one-cycle `ack`, with read data on reads.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles from bus issue until `Bus_rdata` is valid. Legal range 1..7.
- `AW`, default 32: address width.

Ports:
- `cpu_clk` in 1: the single clock; all state changes on its rising edge.
- `cpu_rst` in 1: synchronous, active-low reset. 0 = reset.
- `m0_req` in 1: CPU access request. Held until `m0_ack`.
- `m0_we` in 1: 1 = write.
- `m0_addr` in AW: CPU address.
- `m0_wdata` in 32: CPU write data.
- `m0_gnt` out 1: M0 owns the bus, from ISSUE through DONE.
- `m0_ack` out 1: one-cycle completion pulse to M0.
- `m0_rdata` out 32: read data, valid while `m0_ack`=1.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_ack`, `m1_rdata`: same as the M0 group, for the loader.
- `m1_lock` in 1: while 1, M1 keeps priority across transactions.
- `Bus_addr` out AW: registered bus address.
- `Bus_we` out 1: write strobe, high for exactly one cycle per write.
- `Bus_wdata` out 32: registered bus write data.
- `Bus_rdata` in 32: bus read data.

## Operation
- States:
  - IDLE: choose a winner.
  - ISSUE: drive the bus for one cycle.
  - WAIT: count read latency (reads only).
  - DONE: `ack` for one cycle.
- Transitions:
  - IDLE → ISSUE when any request is pending.
  - ISSUE → DONE for a write.
  - ISSUE → WAIT for a read.
  - WAIT → DONE when the latency counter reaches RD_LAT.
  - DONE → IDLE, always.
- Winner selection in IDLE:
  - If `m1_lock`=1 and `m1_req`=1, M1 wins.
  - Otherwise, if only one master requests, it wins.
  - If both request, the master not granted last wins. The last-granted pointer resets to M1, so M0 wins the first tie.
- On the IDLE→ISSUE edge: the winner's `we`, `addr` and `wdata` are latched into `Bus_*` registers; the grant index and pointer update.
- `Bus_addr` and `Bus_wdata` hold their values until the next IDLE→ISSUE edge.
- `Bus_we` = 1 only in ISSUE and only for a write.
- Read capture: `Bus_rdata` is sampled on the last WAIT cycle (counter = RD_LAT) into the granted master's `rdata` register.
- The non-granted master's `rdata` register is unchanged.
- `mX_gnt` = 1 in ISSUE, WAIT and DONE for the granted master, otherwise 0. Never both 1.
- `mX_ack` = 1 only in DONE, for the granted master.
- A master dropping `req` mid-transaction does not abort it: the transaction completes and `ack` pulses anyway. After DONE no reissue occurs unless `req` is still high in IDLE.
- Inputs of a non-granted master are ignored until it wins.
- Reset (`cpu_rst`=0 at a clock edge, in any state, including mid-WAIT):
  - Next state is IDLE; the pointer resets to M1.
  - All outputs go to 0: `Bus_addr`, `Bus_wdata`, `Bus_we`, both `gnt`, both `ack`, both `rdata`.
  - An interrupted transaction is dropped silently and no `ack` is issued.

## Timing
- Request first seen high in IDLE at cycle t gives:
  - ISSUE at t+1.
  - Write: DONE/`ack` at t+2. Total 2 cycles.
  - Read: WAIT from t+2 to t+1+RD_LAT, DONE/`ack` at t+2+RD_LAT.
- Per-transaction occupancy:
  - Write: 3 cycles (IDLE, ISSUE, DONE).
  - Read: 3+RD_LAT cycles.
- Back-to-back requests from the same master: the next ISSUE follows 2 cycles after DONE (IDLE, then ISSUE).
- Latency counter: 3 bits, loaded with 1 on entry to WAIT, increments each WAIT cycle. No wrap is possible because RD_LAT ≤ 7.
- All outputs are registered or decoded from the state register and grant index. There are no combinational paths from `mX_req` to any output.

## Structure
- Package `bus_arb_pkg` holds:
  - The `arb_state_t` enum (IDLE, ISSUE, WAIT, DONE).
  - Constants `M_CPU`=0 and `M_DBG`=1.
  - The `RD_LAT` legal-range constants.
- Sub-module `arb_rr2` is purely combinational winner selection.
  - Inputs: `req[1:0]`, `lock`, `last`.
  - Outputs: `win`, `valid`.
- The top level holds the FSM, latency counter, latch registers and `rdata` registers.

## Test plan
- Write, M0 only: `m0_addr`=0x0000_0010, `m0_wdata`=0xDEADBEEF. Required response:
  - `Bus_we`=1 for exactly cycle t+1, with `Bus_addr`=0x10 and `Bus_wdata`=0xDEADBEEF.
  - `m0_ack` at t+2.
  - `m1_gnt` stays 0 throughout.
- Read, M1, RD_LAT=2: memory model returns 0x12345678. Required response:
  - `m1_ack` at t+4 with `m1_rdata`=0x12345678.
  - `m0_rdata` unchanged.
- Both masters held high from reset: grants alternate M0, M1, M0, M1. No master is granted twice in a row.
- `m1_lock`=1 with both requesting: three consecutive M1 transactions. Lock drops to 0 and the next grant goes to M0.
- Reset during WAIT (RD_LAT=3): `cpu_rst`=0 for one edge. Next cycle:
  - State is IDLE.
  - All outputs are 0.
  - No `ack` ever appears for the interrupted read.
- M0 drops `req` in WAIT: `m0_ack` still pulses once and no second ISSUE occurs.
